tx_fire_sequencer: RTL and testbench
====================================

# tx_fire_sequencer

Upstream controller for the bank of per-channel transducer output stages. It drives the shared arm/fire strobes (`onYourMark`, `GOGOGO_EXCLAMATION`) and the per-channel timing words (charge time, phase delay, fire delay). It also collects every channel's `fireComplete` and repeats the mark/fire cycle for a programmed pulse train. The host configures it through a small register port and a start/abort pair.

## Interface
- NUM_CH, 8, number of transducer channels driven
- PD_W, 16, phase-delay word width
- MARK_CYCLES, 4, cycles the arm-only phase is held (min 2)
- TIMEOUT_CYCLES, 2^24, fire watchdog limit (used only with FIRE_TIMEOUT_EN)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a pulse train
- abort  in  1  single-cycle request to stop immediately
- cfgWe  in  1  phase-delay write strobe
- cfgAddr  in  $clog2(NUM_CH)  channel index for cfgData
- cfgData  in  PD_W  phase delay for channel cfgAddr
- chanMask  in  NUM_CH  channels to enable; latched on start
- chargeTimeIn  in  9  charge time; latched on start
- fireDelayIn  in  32  common fire delay; latched on start
- numPulses  in  16  pulses in the train; latched on start; 0 is treated as 1
- pulseInterval  in  32  minimum cycles from end of one fire to the next MARK; latched on start
- fireComplete  in  NUM_CH  per-channel completion from the output stages
- isActive  out  NUM_CH  latched chanMask; 0 when idle
- onYourMark  out  1  arm strobe, high in MARK and GO
- GOGOGO_EXCLAMATION  out  1  fire strobe, high in GO only
- chanRst  out  1  one-cycle synchronous reset to the output stages (active-high)
- chargeTime  out  9  latched charge time
- fireDelay  out  32  latched fire delay
- phaseDelay  out  NUM_CH*PD_W  phase-delay register file; channel k occupies bits [k*PD_W +: PD_W]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the train completes normally
- pulseCount  out  16  count of fires completed in the current train
- timeoutErr  out  1  sticky watchdog flag

## Operation
- States: IDLE, MARK, GO, GAP, DONE.
- **IDLE**
  - cfgWe writes cfgData to phaseDelay[cfgAddr]. cfgWe is ignored in every other state.
  - On start: latch all start-latched inputs, clear pulseCount and timeoutErr, then enter MARK.
  - If the latched mask is 0, go to DONE instead, with no strobes.
- **MARK**
  - onYourMark=1, GOGOGO=0 for exactly MARK_CYCLES cycles, then enter GO.
  - Output stages load their delays during this phase.
- **GO**
  - onYourMark=1, GOGOGO=1.
  - Leave when (fireComplete & isActive) == isActive; increment pulseCount on exit.
  - If pulseCount now equals the target, enter DONE; otherwise enter GAP.
- **GAP**
  - Both strobes are 0.
  - Count pulseInterval cycles and also wait for (fireComplete & isActive) == 0, then enter MARK.
- **DONE**
  - done=1 for one cycle, then enter IDLE; isActive is cleared.
- **abort** (any non-IDLE state)
  - Next state is IDLE and both strobes drop. chanRst=1 for one cycle. No done pulse.
  - pulseCount holds its value.
- start while busy is ignored. start and abort in the same cycle: abort wins, so start is ignored even in IDLE.
- Inactive channels report fireComplete=1 permanently. They are excluded from both checks by the mask.

## Timing
- Reset values: every output is 0, the phaseDelay file is 0, and the state is IDLE.
- start sampled high at edge N gives onYourMark=1 from edge N+1.
- GOGOGO rises at edge N+1+MARK_CYCLES.
- GO exit: the all-complete condition sampled at edge M drops both strobes at edge M+1.
- Done-bound exits: done=1 during cycle M+1 and busy=0 from edge M+2.
- GAP: the interval counter starts at the GO-exit edge. pulseInterval=0 means MARK follows as soon as the fireComplete lines are low.
- pulseCount compares at 16 bits and never wraps; numPulses=65535 is the maximum train.
- Reset asserted mid-train forces IDLE asynchronously, with all strobes 0 immediately.

## Configuration
- FIRE_TIMEOUT_EN defined:
  - a 32-bit watchdog counts cycles spent in GO;
  - reaching TIMEOUT_CYCLES sets timeoutErr and takes the abort path (chanRst pulse, IDLE).
- Not defined: no watchdog logic; timeoutErr is tied to 0 and GO can last indefinitely.

## Structure
- Shared package `tx_pkg`: the state enum, the PD_W and charge-time widths, and the default MARK_CYCLES.
- One sub-module, `tx_phase_regfile`: the NUM_CH×PD_W write-only register file with its flattened output.
- Sequencing logic lives in the top level.

## Test plan
- NUM_CH=8, mask=8'h0F, numPulses=1, MARK_CYCLES=4:
  - onYourMark rises 1 cycle after start and GOGOGO 5 cycles after start;
  - strobes drop 1 cycle after fireComplete[3:0] are all high; done pulses once; pulseCount=1.
- numPulses=3, pulseInterval=10:
  - three MARK/GO cycles, each GAP at least 10 cycles and held until the active fireComplete lines are low;
  - done after the third fire; pulseCount=3.
- Write phaseDelay[5]=16'h1234 in IDLE, then attempt a write to [5] while busy:
  - field 5 reads 16'h1234 and the busy-time write is ignored.
- abort two cycles into GO:
  - strobes low next cycle, chanRst one-cycle pulse, no done, busy=0.
- mask=0, start:
  - done pulses 1 cycle after start and onYourMark never rises.
- With FIRE_TIMEOUT_EN and TIMEOUT_CYCLES=100, fireComplete held low:
  - at the 100th GO cycle, timeoutErr=1 sticky plus a chanRst pulse, then IDLE;
  - the next start clears timeoutErr.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared types and default widths for the transducer fire sequencer.
// Optional watchdog in tx_fire_sequencer is enabled by FIRE_TIMEOUT_EN.
package tx_pkg;

    localparam int unsigned TX_PD_W        = 16;
    localparam int unsigned TX_CHARGE_W    = 9;
    localparam int unsigned TX_MARK_CYCLES = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MARK = 3'd1,
        S_GO   = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } txState_e;

endpackage

// File: rtl/tx_phase_regfile.sv
// Write-only per-channel phase-delay register file with a flattened output bus.
// Channel k occupies phaseDelay[k*PD_W +: PD_W].
module tx_phase_regfile
    import tx_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned PD_W   = TX_PD_W,
    localparam int unsigned AW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic [PD_W-1:0]          data,
    output logic [NUM_CH*PD_W-1:0]   phaseDelay
);

    // Addresses beyond NUM_CH-1 match no channel and are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phaseDelay <= '0;
        end else if (we) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (addr == AW'(k)) begin
                    phaseDelay[k*PD_W +: PD_W] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/tx_fire_sequencer.sv
// Mark/fire pulse-train sequencer for the transducer output-stage bank.
// Define FIRE_TIMEOUT_EN to add the GO-state watchdog (TIMEOUT_CYCLES, timeoutErr).
module tx_fire_sequencer
    import tx_pkg::*;
#(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned PD_W           = TX_PD_W,
    parameter int unsigned MARK_CYCLES    = TX_MARK_CYCLES,
`ifdef FIRE_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216,
`endif
    localparam int unsigned AW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned MW            = $clog2(MARK_CYCLES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cfgWe,
    input  logic [AW-1:0]             cfgAddr,
    input  logic [PD_W-1:0]           cfgData,
    input  logic [NUM_CH-1:0]         chanMask,
    input  logic [TX_CHARGE_W-1:0]    chargeTimeIn,
    input  logic [31:0]               fireDelayIn,
    input  logic [15:0]               numPulses,
    input  logic [31:0]               pulseInterval,
    input  logic [NUM_CH-1:0]         fireComplete,
    output logic [NUM_CH-1:0]         isActive,
    output logic                      onYourMark,
    output logic                      GOGOGO_EXCLAMATION,
    output logic                      chanRst,
    output logic [TX_CHARGE_W-1:0]    chargeTime,
    output logic [31:0]               fireDelay,
    output logic [NUM_CH*PD_W-1:0]    phaseDelay,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               pulseCount,
    output logic                      timeoutErr
);

    txState_e    state, stateNext;
    logic [MW-1:0] markCnt;
    logic [31:0] gapCnt;
    logic [31:0] gapLen;
    logic [15:0] pulseTarget;

    logic startOk, allComplete, allClear, markDone, gapDone, lastPulse;
    logic goExit, timeoutHit, wdFire, abortPath;
    logic onYourMarkD, gogoD, busyD, doneD, chanRstD;

    // Masked channels read 1 permanently, so both checks ignore them.
    assign allComplete = ((fireComplete & isActive) == isActive);
    assign allClear    = ((fireComplete & isActive) == '0);
    assign startOk     = (state == S_IDLE) && start && !abort;
    assign markDone    = (markCnt == MW'(MARK_CYCLES - 1));
    assign gapDone     = (gapCnt >= gapLen);
    assign lastPulse   = ((pulseCount + 16'd1) == pulseTarget);
    assign goExit      = (state == S_GO) && allComplete && !abort;
    assign wdFire      = (state == S_GO) && !allComplete && timeoutHit;
    assign abortPath   = ((state != S_IDLE) && abort) || wdFire;

    tx_phase_regfile #(
        .NUM_CH (NUM_CH),
        .PD_W   (PD_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we         (cfgWe && (state == S_IDLE)),
        .addr       (cfgAddr),
        .data       (cfgData),
        .phaseDelay (phaseDelay)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        if (abortPath) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (startOk) stateNext = (chanMask == '0) ? S_DONE : S_MARK;
                S_MARK: if (markDone) stateNext = S_GO;
                S_GO:   if (allComplete) stateNext = lastPulse ? S_DONE : S_GAP;
                S_GAP:  if (gapDone && allClear) stateNext = S_MARK;
                S_DONE: stateNext = S_IDLE;
                default: stateNext = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state; registered below
    always_comb begin
        onYourMarkD = 1'b0;
        gogoD       = 1'b0;
        busyD       = 1'b0;
        doneD       = 1'b0;
        chanRstD    = abortPath;
        case (stateNext)
            S_MARK: begin onYourMarkD = 1'b1; busyD = 1'b1; end
            S_GO:   begin onYourMarkD = 1'b1; gogoD = 1'b1; busyD = 1'b1; end
            S_GAP:  busyD = 1'b1;
            S_DONE: begin busyD = 1'b1; doneD = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            onYourMark         <= 1'b0;
            GOGOGO_EXCLAMATION <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            chanRst            <= 1'b0;
        end else begin
            onYourMark         <= onYourMarkD;
            GOGOGO_EXCLAMATION <= gogoD;
            busy               <= busyD;
            done               <= doneD;
            chanRst            <= chanRstD;
        end
    end

    // Train configuration latched on start; pulseCount holds through abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isActive    <= '0;
            chargeTime  <= '0;
            fireDelay   <= '0;
            pulseTarget <= '0;
            gapLen      <= '0;
            pulseCount  <= '0;
        end else if (startOk) begin
            isActive    <= chanMask;
            chargeTime  <= chargeTimeIn;
            fireDelay   <= fireDelayIn;
            pulseTarget <= (numPulses == 16'd0) ? 16'd1 : numPulses;
            gapLen      <= pulseInterval;
            pulseCount  <= '0;
        end else begin
            if (stateNext == S_IDLE) isActive <= '0;
            if (goExit) pulseCount <= pulseCount + 16'd1;
        end
    end

    // gapCnt reads 1 in the first GAP cycle so gapDone means "interval elapsed"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            markCnt <= '0;
            gapCnt  <= 32'd1;
        end else begin
            markCnt <= (state == S_MARK) ? markCnt + MW'(1) : '0;
            if (state != S_GAP)      gapCnt <= 32'd1;
            else if (gapCnt != '1)   gapCnt <= gapCnt + 32'd1;
        end
    end

`ifdef FIRE_TIMEOUT_EN
    logic [31:0] wdCnt;

    assign timeoutHit = (wdCnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdCnt      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            wdCnt <= (state == S_GO) ? wdCnt + 32'd1 : '0;
            if (startOk)     timeoutErr <= 1'b0;
            else if (wdFire) timeoutErr <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign timeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Self-checking bench for tx_fire_sequencer: table-driven pulse trains plus
// hand-written abort, busy-write, timeout and async-reset sequences.
`timescale 1ns/1ps
module tb_tx_fire_sequencer;

    localparam int unsigned NUM_CH      = 8;
    localparam int unsigned PD_W        = 16;
    localparam int unsigned MARK_CYCLES = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     cfgWe = 1'b0;
    logic [2:0]               cfgAddr = '0;
    logic [PD_W-1:0]          cfgData = '0;
    logic [NUM_CH-1:0]        chanMask = '0;
    logic [8:0]               chargeTimeIn = '0;
    logic [31:0]              fireDelayIn = '0;
    logic [15:0]              numPulses = '0;
    logic [31:0]              pulseInterval = '0;
    logic [NUM_CH-1:0]        fireComplete = '0;
    logic [NUM_CH-1:0]        isActive;
    logic                     onYourMark;
    logic                     GOGOGO_EXCLAMATION;
    logic                     chanRst;
    logic [8:0]               chargeTime;
    logic [31:0]              fireDelay;
    logic [NUM_CH*PD_W-1:0]   phaseDelay;
    logic                     busy;
    logic                     done;
    logic [15:0]              pulseCount;
    logic                     timeoutErr;

    int checks = 0;
    int failures = 0;
    int expQ[$];

    typedef struct {
        logic [7:0]  mask;
        logic [15:0] np;
        logic [31:0] interval;
        int          hold;
        int          fireLat;
        int          expPulses;
    } vec_t;

    vec_t vecs[6];

    tx_fire_sequencer #(
        .NUM_CH         (NUM_CH),
        .PD_W           (PD_W),
`ifdef FIRE_TIMEOUT_EN
        .TIMEOUT_CYCLES (100),
`endif
        .MARK_CYCLES    (MARK_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .cfgWe              (cfgWe),
        .cfgAddr            (cfgAddr),
        .cfgData            (cfgData),
        .chanMask           (chanMask),
        .chargeTimeIn       (chargeTimeIn),
        .fireDelayIn        (fireDelayIn),
        .numPulses          (numPulses),
        .pulseInterval      (pulseInterval),
        .fireComplete       (fireComplete),
        .isActive           (isActive),
        .onYourMark         (onYourMark),
        .GOGOGO_EXCLAMATION (GOGOGO_EXCLAMATION),
        .chanRst            (chanRst),
        .chargeTime         (chargeTime),
        .fireDelay          (fireDelay),
        .phaseDelay         (phaseDelay),
        .busy               (busy),
        .done               (done),
        .pulseCount         (pulseCount),
        .timeoutErr         (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each done pulse consumes one expected final pulseCount.
    always @(negedge clk) begin
        int e;
        if (rst && done) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL doneUnexpected actual=done required=no_done pulseCount=%0d", pulseCount);
            end else begin
                e = expQ.pop_front();
                chk("donePulseCount", 64'(pulseCount), 64'(e));
            end
        end
    end

    task automatic runTrain(input vec_t v);
        int cnt;
        int gapExp;
        chanMask      = v.mask;
        numPulses     = v.np;
        pulseInterval = v.interval;
        chargeTimeIn  = 9'h1A5;
        fireDelayIn   = 32'hCAFE_0000 + v.interval;
        fireComplete  = ~v.mask;
        expQ.push_back(v.expPulses);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (v.mask == 8'h00) begin
            chk("zeroMaskDone", 64'(done), 64'd1);
            chk("zeroMaskNoMark", 64'({onYourMark, GOGOGO_EXCLAMATION}), 64'd0);
            tick();
            chk("zeroMaskIdle", 64'({done, busy, onYourMark}), 64'd0);
            return;
        end
        chk("startBusyMask", 64'({busy, isActive}), 64'({1'b1, v.mask}));
        chk("latchTiming", 64'({chargeTime, fireDelay}), 64'({9'h1A5, 32'hCAFE_0000 + v.interval}));
        for (int p = 0; p < v.expPulses; p++) begin
            cnt = 0;
            while (onYourMark && !GOGOGO_EXCLAMATION && cnt < 20) begin
                cnt++;
                tick();
            end
            chk("markLen", 64'(cnt), 64'(MARK_CYCLES));
            chk("goStrobes", 64'({onYourMark, GOGOGO_EXCLAMATION}), 64'd3);
            repeat (v.fireLat) tick();
            chk("goHeld", 64'(GOGOGO_EXCLAMATION), 64'd1);
            fireComplete = '1;
            tick();
            chk("strobesDrop", 64'({onYourMark, GOGOGO_EXCLAMATION}), 64'd0);
            chk("pulseCount", 64'(pulseCount), 64'(p + 1));
            if (p == v.expPulses - 1) begin
                chk("doneHigh", 64'(done), 64'd1);
                tick();
                chk("trainIdle", 64'({done, busy, isActive}), 64'd0);
            end else begin
                chk("gapNoDone", 64'({done, busy}), 64'b01);
                gapExp = (int'(v.interval) > v.hold + 1) ? int'(v.interval) : v.hold + 1;
                cnt = 0;
                while (!onYourMark && cnt < 200) begin
                    if (cnt == v.hold) fireComplete = ~v.mask;
                    cnt++;
                    tick();
                end
                chk("gapLen", 64'(cnt), 64'(gapExp));
            end
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{8'h0F, 16'd1, 32'd0,  0, 3, 1};
        vecs[1] = '{8'hFF, 16'd3, 32'd10, 2, 2, 3};
        vecs[2] = '{8'h81, 16'd2, 32'd3,  6, 1, 2};
        vecs[3] = '{8'h3C, 16'd0, 32'd0,  0, 0, 1};
        vecs[4] = '{8'h00, 16'd4, 32'd0,  0, 0, 0};
        vecs[5] = '{8'h01, 16'd2, 32'd1,  0, 0, 2};

        repeat (3) tick();
        chk("rstInReset", 64'({isActive, onYourMark, GOGOGO_EXCLAMATION, chanRst, busy, done, timeoutErr}), 64'd0);
        rst = 1'b1;
        tick();
        chk("rstLatched", 64'({chargeTime, fireDelay}), 64'd0);
        chk("rstPdLow", phaseDelay[63:0], 64'd0);
        chk("rstPdHigh", phaseDelay[127:64], 64'd0);
        chk("rstCount", 64'(pulseCount), 64'd0);

        for (int i = 0; i < 6; i++) runTrain(vecs[i]);

        // Phase-delay write in IDLE, then a write and a start while busy.
        cfgAddr = 3'd5; cfgData = 16'h1234; cfgWe = 1'b1;
        tick();
        cfgWe = 1'b0;
        chk("pdWrite", 64'(phaseDelay[5*PD_W +: PD_W]), 64'h1234);
        chk("pdNeighbour", 64'(phaseDelay[4*PD_W +: PD_W]), 64'd0);
        chanMask = 8'h01; numPulses = 16'd2; pulseInterval = 32'd0; fireComplete = 8'hFE;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfgData = 16'hBEEF; cfgWe = 1'b1; chanMask = 8'hFF; start = 1'b1;
        tick();
        cfgWe = 1'b0; start = 1'b0;
        chk("busyWriteIgnored", 64'(phaseDelay[5*PD_W +: PD_W]), 64'h1234);
        chk("busyStartIgnored", 64'(isActive), 64'h01);
        cnt = 0;
        while (!GOGOGO_EXCLAMATION && cnt < 20) begin cnt++; tick(); end
        fireComplete = 8'hFF;
        tick();
        fireComplete = 8'hFE;
        cnt = 0;
        while (!GOGOGO_EXCLAMATION && cnt < 40) begin cnt++; tick(); end
        chk("secondGo", 64'(GOGOGO_EXCLAMATION), 64'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abortStrobes", 64'({onYourMark, GOGOGO_EXCLAMATION}), 64'd0);
        chk("abortChanRst", 64'(chanRst), 64'd1);
        chk("abortIdle", 64'({busy, done, isActive}), 64'd0);
        chk("abortHoldsCount", 64'(pulseCount), 64'd1);
        tick();
        chk("chanRstOnePulse", 64'(chanRst), 64'd0);

        // start and abort together in IDLE: abort wins.
        chanMask = 8'h0F; numPulses = 16'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("startAbortIgnored", 64'({busy, onYourMark, chanRst}), 64'd0);

        // Long GO with fireComplete held low.
        fireComplete = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!GOGOGO_EXCLAMATION && cnt < 20) begin cnt++; tick(); end
`ifdef FIRE_TIMEOUT_EN
        cnt = 0;
        while (GOGOGO_EXCLAMATION && cnt < 300) begin cnt++; tick(); end
        chk("timeoutGoLen", 64'(cnt), 64'd100);
        chk("timeoutFlags", 64'({timeoutErr, chanRst, busy, done}), 64'b1100);
        tick();
        chk("timeoutSticky", 64'({timeoutErr, chanRst}), 64'b10);
        chanMask = 8'h00;
        expQ.push_back(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("timeoutCleared", 64'({timeoutErr, done}), 64'b01);
        tick();
`else
        repeat (150) tick();
        chk("noWatchdogGo", 64'({GOGOGO_EXCLAMATION, timeoutErr}), 64'b10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("noWatchdogAbort", 64'({busy, chanRst}), 64'b01);
        tick();
`endif

        // Asynchronous reset mid-train.
        chanMask = 8'h0F; numPulses = 16'd1; fireComplete = 8'hF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!GOGOGO_EXCLAMATION && cnt < 20) begin cnt++; tick(); end
        #2 rst = 1'b0;
        #1;
        chk("asyncRstStrobes", 64'({onYourMark, GOGOGO_EXCLAMATION, busy, isActive}), 64'd0);
        chk("asyncRstRegfile", 64'(phaseDelay[5*PD_W +: PD_W]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("postRstIdle", 64'({busy, onYourMark, done}), 64'd0);

        chk("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tbWatchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
